// File: rtl/cfg_dprio_status_read_pkg.sv
// Shared definitions for the DPRIO status-read requester.
package cfg_dprio_status_read_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    REL     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/cdclib_bitsync2.sv
// Two-flop level synchronizer with asynchronous active-low reset.
module cdclib_bitsync2 #(
  parameter int              DWIDTH       = 1,
  parameter logic [DWIDTH-1:0] RESET_VAL  = '0,
  parameter int              CLK_FREQ_MHZ = 250,
  parameter int              TOGGLE_TYPE  = 1,
  parameter int              VID          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out
);

  // Library tuning parameters; a non-physical setting leaves the output parked at RESET_VAL.
  if (CLK_FREQ_MHZ > 0 && TOGGLE_TYPE >= 0 && VID >= 0) begin : g_sync
    logic [DWIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta     <= RESET_VAL;
        data_out <= RESET_VAL;
      end else begin
        meta     <= data_in;
        data_out <= meta;
      end
    end
  end else begin : g_parked
    assign data_out = RESET_VAL;
  end

endmodule

// File: rtl/cfg_dprio_status_read_ctrl.sv
// DPRIO-side requester: 4-phase write_en/ack handshake with the shadow status block,
// then one capture of the frozen status bus.
module cfg_dprio_status_read_ctrl
  import cfg_dprio_status_read_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CLK_FREQ_MHZ   = 250,
  parameter int TOGGLE_TYPE    = 1,
  parameter int VID            = 1,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  output logic                  rd_busy,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_timeout,
  output logic                  write_en,
  input  logic                  write_en_ack,
  input  logic [DATA_WIDTH-1:0] stat_data
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  state;
  logic                    ack_s;
  logic [TMO_W-1:0]        tmo;
  logic [SETTLE_CNT_W-1:0] cnt;
  logic                    tmo_hit;

  cdclib_bitsync2 #(
    .DWIDTH       (1),
    .RESET_VAL    (1'b0),
    .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
    .TOGGLE_TYPE  (TOGGLE_TYPE),
    .VID          (VID)
  ) u_ack_sync (
    .clk      (clk),
    .rst_n    (!rst),
    .data_in  (write_en_ack),
    .data_out (ack_s)
  );

  // A zero timeout disables expiry; tmo then simply wraps.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo == TMO_LAST);

  // A still-high ack_s in IDLE means a previous handshake has not drained.
  assign rd_busy = (state != IDLE) || ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      write_en      <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_timeout    <= 1'b0;
      rd_data       <= '0;
      tmo           <= '0;
      cnt           <= '0;
    end else begin
      rd_data_valid <= 1'b0;
      rd_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req && !ack_s) begin
            write_en <= 1'b1;
            tmo      <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            write_en <= 1'b0;
            tmo      <= '0;
            state    <= REL;
          end else if (tmo_hit) begin
            write_en   <= 1'b0;
            rd_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        REL: begin
          if (!ack_s) begin
            cnt   <= '0;
            state <= SETTLE;
          end else if (tmo_hit) begin
            rd_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SETTLE_LAST) state <= CAPTURE;
        end
        CAPTURE: begin
          // Shadow update is stopped here, so the multi-bit bus is stable.
          rd_data       <= stat_data;
          rd_data_valid <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          write_en <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
